// File: rtl/asym_wave_gen.sv
// Table-driven asymmetric waveform generator: NSEG (level, duration) segments played once or in a loop.
// Optional WAVE_LOOP_CNT_EN adds a pass counter and a bounded loop count.
module asym_wave_gen #(
  parameter int   NSEG       = 4,
  parameter int   CNT_W      = 8,
  parameter int   IDX_W      = $clog2(NSEG),
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic             cfg_level,
  input  logic [CNT_W-1:0] cfg_dur,
  input  logic [IDX_W:0]   cfg_len,
  input  logic             one_shot,
  input  logic             start,
  input  logic             stop,
  output logic             wave_out,
  output logic             busy,
  output logic [IDX_W-1:0] seg_idx,
  output logic             done
`ifdef WAVE_LOOP_CNT_EN
  ,
  input  logic [7:0]       loops,
  output logic [7:0]       loop_cnt
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [IDX_W:0] NSEG_L = (IDX_W+1)'(NSEG);

  state_t           r_state, w_state_nxt;
  logic [NSEG-1:0]  r_level;
  logic [CNT_W-1:0] r_dur [NSEG];
  logic             r_active, w_active_nxt;
  logic [IDX_W:0]   r_len, w_len_nxt, w_len_eff;
  logic             r_one_shot, w_one_shot_nxt;
  logic [IDX_W-1:0] r_seg_idx, w_seg_idx_nxt, w_next_idx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_wave, w_wave_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_last, w_finish;
`ifdef WAVE_LOOP_CNT_EN
  logic [7:0]       r_loops, w_loops_nxt;
  logic [7:0]       r_loop_cnt, w_loop_cnt_nxt;
`endif

  // A zero duration plays as one cycle, so the reload value is dur-1 clamped at 0.
  function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  assign w_len_eff  = (cfg_len == '0) ? (IDX_W+1)'(1) :
                      (cfg_len > NSEG_L) ? NSEG_L : cfg_len;
  assign w_next_idx = r_seg_idx + IDX_W'(1);
  assign w_last     = ({1'b0, r_seg_idx} == (r_len - (IDX_W+1)'(1)));

  always_comb begin
    w_finish = r_one_shot;
`ifdef WAVE_LOOP_CNT_EN
    if (r_loops != 8'd0 && (r_loop_cnt + 8'd1) == r_loops) w_finish = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_active_nxt   = r_active;
    w_len_nxt      = r_len;
    w_one_shot_nxt = r_one_shot;
    w_seg_idx_nxt  = r_seg_idx;
    w_cnt_nxt      = r_cnt;
    w_wave_nxt     = r_wave;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
`ifdef WAVE_LOOP_CNT_EN
    w_loops_nxt    = r_loops;
    w_loop_cnt_nxt = r_loop_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_wave_nxt    = IDLE_LEVEL;
        w_busy_nxt    = 1'b0;
        w_seg_idx_nxt = '0;
        w_cnt_nxt     = '0;
        w_active_nxt  = 1'b0;
        if (start && !stop) begin
          w_state_nxt    = S_RUN;
          w_len_nxt      = w_len_eff;
          w_one_shot_nxt = one_shot;
`ifdef WAVE_LOOP_CNT_EN
          w_loops_nxt    = loops;
          w_loop_cnt_nxt = 8'd0;
`endif
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt   = S_IDLE;
          w_wave_nxt    = IDLE_LEVEL;
          w_busy_nxt    = 1'b0;
          w_seg_idx_nxt = '0;
          w_cnt_nxt     = '0;
          w_active_nxt  = 1'b0;
        end else if (!r_active) begin
          // First RUN cycle loads segment 0 after any same-cycle table write has landed.
          w_active_nxt  = 1'b1;
          w_busy_nxt    = 1'b1;
          w_seg_idx_nxt = '0;
          w_wave_nxt    = r_level[0];
          w_cnt_nxt     = load_of(r_dur[0]);
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!w_last) begin
          w_seg_idx_nxt = w_next_idx;
          w_wave_nxt    = r_level[w_next_idx];
          w_cnt_nxt     = load_of(r_dur[w_next_idx]);
        end else begin
`ifdef WAVE_LOOP_CNT_EN
          if (r_loop_cnt != 8'hFF) w_loop_cnt_nxt = r_loop_cnt + 8'd1;
`endif
          if (w_finish) begin
            w_state_nxt   = S_IDLE;
            w_wave_nxt    = IDLE_LEVEL;
            w_busy_nxt    = 1'b0;
            w_seg_idx_nxt = '0;
            w_cnt_nxt     = '0;
            w_active_nxt  = 1'b0;
            w_done_nxt    = 1'b1;
          end else begin
            w_seg_idx_nxt = '0;
            w_wave_nxt    = r_level[0];
            w_cnt_nxt     = load_of(r_dur[0]);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_level    <= '0;
      for (int i = 0; i < NSEG; i++) r_dur[i] <= '0;
      r_active   <= 1'b0;
      r_len      <= '0;
      r_one_shot <= 1'b0;
      r_seg_idx  <= '0;
      r_cnt      <= '0;
      r_wave     <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef WAVE_LOOP_CNT_EN
      r_loops    <= 8'd0;
      r_loop_cnt <= 8'd0;
`endif
    end else begin
      if (cfg_we && r_state == S_IDLE) begin
        r_level[cfg_addr] <= cfg_level;
        r_dur[cfg_addr]   <= cfg_dur;
      end
      r_active   <= w_active_nxt;
      r_len      <= w_len_nxt;
      r_one_shot <= w_one_shot_nxt;
      r_seg_idx  <= w_seg_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wave     <= w_wave_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef WAVE_LOOP_CNT_EN
      r_loops    <= w_loops_nxt;
      r_loop_cnt <= w_loop_cnt_nxt;
`endif
    end
  end

  assign wave_out = r_wave;
  assign busy     = r_busy;
  assign seg_idx  = r_seg_idx;
  assign done     = r_done;
`ifdef WAVE_LOOP_CNT_EN
  assign loop_cnt = r_loop_cnt;
`endif

endmodule
